// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 codes, LSU state encoding,
// size masks and the captured-request payload.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE0 = 2'd1,
    ISSUE1 = 2'd2,
    DONE   = 2'd3
  } lsu_state_t;

  // Everything about an accepted request that outlives the handshake.
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        split;
    logic        err;
    logic [31:0] wdata;
  } lsu_op_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic [3:0] f3_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return MASK_B;
      2'b01:   return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response and lane-memory signals of the load/store unit.
interface lsu_ctrl_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_be;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_be, mem_we, mem_re, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_be, mem_we, mem_re, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Lane alignment: byte enables and shifted write data for both words of an
// access, plus shift and sign/zero extension of returned load data.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        split,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_cur,
  input  logic [31:0] rdata_buf,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] load_data
);

  logic [7:0]  be_full;
  logic [63:0] wd_full;
  logic [63:0] rd_full;
  logic [31:0] rd_shift;

  // A 64-bit window over two words: the upper half is what spills into word1.
  always_comb begin
    be_full  = 8'(f3_mask(funct3)) << off;
    wd_full  = 64'(wdata) << {off, 3'b000};
    be0      = be_full[3:0];
    be1      = be_full[7:4];
    wdata0   = wd_full[31:0];
    wdata1   = wd_full[63:32];
  end

  always_comb begin
    rd_full  = split ? {rdata_cur, rdata_buf} : {32'b0, rdata_cur};
    rd_shift = 32'(rd_full >> {off, 3'b000});
    case (funct3)
      F3_B:    load_data = {{24{rd_shift[7]}},  rd_shift[7:0]};
      F3_H:    load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      F3_BU:   load_data = {24'b0, rd_shift[7:0]};
      F3_HU:   load_data = {16'b0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the MEM stage and a four-lane data memory;
// splits misaligned accesses into two word accesses.
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  lsu_ctrl_if.slave   bus
);

  localparam int unsigned WORD_W = ADDR_W - 2;

  lsu_state_t        state;
  lsu_op_t           op_q;
  lsu_op_t           acc_op;
  logic [WORD_W-1:0] word0_q;
  logic [31:0]       buf0_q;

  logic [3:0]        be0;
  logic [3:0]        be1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic [31:0]       load_data;

  // Decode of the request as presented; only latched on acceptance.
  always_comb begin
    acc_op        = '0;
    acc_op.we     = bus.req_we;
    acc_op.funct3 = bus.req_funct3;
    acc_op.off    = bus.req_addr[1:0];
    acc_op.wdata  = bus.req_wdata;
    acc_op.err    = !f3_legal(bus.req_we, bus.req_funct3) ||
                    (|bus.req_addr[31:ADDR_W]);
    acc_op.split  = ((bus.req_funct3[1:0] == F3_H[1:0]) && (bus.req_addr[1:0] == 2'b11)) ||
                    ((bus.req_funct3[1:0] == F3_W[1:0]) && (bus.req_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      word0_q <= '0;
      buf0_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q    <= acc_op;
            word0_q <= bus.req_addr[ADDR_W-1:2];
            state   <= acc_op.err ? DONE : ISSUE0;
          end
        end
        ISSUE0:  state <= op_q.split ? ISSUE1 : DONE;
        ISSUE1: begin
          buf0_q <= bus.mem_rdata;
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  lsu_align u_align (
    .funct3    (op_q.funct3),
    .off       (op_q.off),
    .split     (op_q.split),
    .wdata     (op_q.wdata),
    .rdata_cur (bus.mem_rdata),
    .rdata_buf (buf0_q),
    .be0       (be0),
    .be1       (be1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .load_data (load_data)
  );

  // State decode; reset forces every strobe and the response low in its own cycle.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_wdata = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    if (!rst) begin
      case (state)
        IDLE: bus.req_ready = 1'b1;
        ISSUE0: begin
          bus.mem_addr  = word0_q;
          bus.mem_be    = be0;
          bus.mem_wdata = wdata0;
          bus.mem_we    = op_q.we;
          bus.mem_re    = !op_q.we;
        end
        ISSUE1: begin
          bus.mem_addr  = word0_q + WORD_W'(1);
          bus.mem_be    = be1;
          bus.mem_wdata = wdata1;
          bus.mem_we    = op_q.we;
          bus.mem_re    = !op_q.we;
        end
        DONE: begin
          bus.rsp_valid = 1'b1;
          bus.rsp_err   = op_q.err;
          bus.rsp_rdata = (op_q.err || op_q.we) ? 32'b0 : load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a byte-addressed reference model of
// the 2 KB data memory.
module tb_lsu_ctrl;
  import riscv_pkg::*;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned MEM_BYTES = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem    [MEM_BYTES];
  logic [7:0] shadow [MEM_BYTES];
  bit         mem_init_done = 1'b0;

  // Lane memory seen by the DUT; filled with random bytes on the first edge.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'($urandom);
      mem_init_done <= 1'b1;
    end else begin
      if (bus.mem_we)
        for (int k = 0; k < 4; k++)
          if (bus.mem_be[k]) mem[{bus.mem_addr, 2'(k)}] <= bus.mem_wdata[8*k +: 8];
      if (bus.mem_re)
        bus.mem_rdata <= {mem[{bus.mem_addr, 2'd3}], mem[{bus.mem_addr, 2'd2}],
                          mem[{bus.mem_addr, 2'd1}], mem[{bus.mem_addr, 2'd0}]};
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic mem_check(input string tag);
    int diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== shadow[i]) diffs++;
    check_val(tag, 32'(diffs), 32'd0);
  endtask

  // One request end to end: model computed from byte addresses, then driven and observed.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] o_rdata);
    logic        legal, err, split;
    int          n, off, exp_lat, exp_ns, lat, ns, guard;
    logic [31:0] exp_rdata, got_rdata, lane_mask;
    logic        got_err;
    logic [63:0] v;
    logic [8:0]  ew  [2];
    logic [3:0]  ebe [2];
    logic [31:0] ewd [2];
    logic [8:0]  oaddr [2];
    logic [3:0]  obe [2];
    logic [31:0] owd [2];
    logic        owe [2];
    logic        ore [2];

    legal = we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
               : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    err   = !legal || (addr >= MEM_BYTES);
    n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off   = int'(addr[1:0]);
    split = (off + n > 4);
    exp_lat = err ? 1 : (split ? 3 : 2);
    exp_ns  = err ? 0 : (split ? 2 : 1);
    ew[0] = addr[10:2];
    ew[1] = addr[10:2] + 9'd1;
    for (int s = 0; s < 2; s++) begin
      ebe[s] = '0; ewd[s] = '0; oaddr[s] = '0; obe[s] = '0; owd[s] = '0; owe[s] = 1'b0; ore[s] = 1'b0;
    end
    v = '0;
    for (int i = 0; i < n; i++) begin
      int a;
      a = (int'(addr[10:0]) + i) % MEM_BYTES;
      v[8*i +: 8] = mem[a];
      if (off + i < 4) begin
        ebe[0][off+i] = 1'b1;
        ewd[0][8*(off+i) +: 8] = wd[8*i +: 8];
      end else begin
        ebe[1][off+i-4] = 1'b1;
        ewd[1][8*(off+i-4) +: 8] = wd[8*i +: 8];
      end
    end
    if (err || we) exp_rdata = '0;
    else case (f3)
      F3_B:    exp_rdata = {{24{v[7]}}, v[7:0]};
      F3_H:    exp_rdata = {{16{v[15]}}, v[15:0]};
      F3_BU:   exp_rdata = {24'b0, v[7:0]};
      F3_HU:   exp_rdata = {16'b0, v[15:0]};
      default: exp_rdata = v[31:0];
    endcase

    guard = 0;
    while (!bus.req_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check_val("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;

    lat = 0; ns = 0; got_err = 1'b0; got_rdata = '0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.mem_we || bus.mem_re) begin
        if (ns < 2) begin
          oaddr[ns] = bus.mem_addr; obe[ns] = bus.mem_be; owd[ns] = bus.mem_wdata;
          owe[ns] = bus.mem_we; ore[ns] = bus.mem_re;
        end
        ns++;
      end
      if (bus.rsp_valid) begin
        lat = k; got_err = bus.rsp_err; got_rdata = bus.rsp_rdata;
        break;
      end
    end

    check_val("latency", 32'(lat), 32'(exp_lat));
    check_val("rsp_err", 32'(got_err), 32'(err));
    check_val("rsp_rdata", got_rdata, exp_rdata);
    check_val("strobe_cycles", 32'(ns), 32'(exp_ns));
    for (int s = 0; s < 2; s++) begin
      if (s < exp_ns && s < ns) begin
        check_val($sformatf("acc%0d_addr", s), 32'(oaddr[s]), 32'(ew[s]));
        check_val($sformatf("acc%0d_be", s), 32'(obe[s]), 32'(ebe[s]));
        check_val($sformatf("acc%0d_we", s), 32'(owe[s]), 32'(we));
        check_val($sformatf("acc%0d_re", s), 32'(ore[s]), 32'(!we));
        if (we) begin
          for (int b = 0; b < 4; b++) lane_mask[8*b +: 8] = {8{ebe[s][b]}};
          check_val($sformatf("acc%0d_wdata", s), owd[s] & lane_mask, ewd[s]);
        end
      end
    end
    if (we && !err) begin
      for (int i = 0; i < n; i++) shadow[(int'(addr[10:0]) + i) % MEM_BYTES] = wd[8*i +: 8];
      mem_check("mem_after_store");
    end
    o_rdata = got_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    repeat (3) @(negedge clk);
    check_val("rst_ready", 32'(bus.req_ready), 32'd0);
    check_val("rst_strobes", {29'b0, bus.mem_we, bus.mem_re, |bus.mem_be}, 32'd0);
    rst = 1'b0;
    #1;
    check_val("idle_ready", 32'(bus.req_ready), 32'd1);
    check_val("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_val("idle_rsp_err", 32'(bus.rsp_err), 32'd0);
    check_val("idle_rsp_rdata", bus.rsp_rdata, 32'd0);
    for (int i = 0; i < MEM_BYTES; i++) shadow[i] = mem[i];

    run_op(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd);
    run_op(1'b0, F3_W, 32'h10, 32'h0, rd);
    check_val("lw_0x10", rd, 32'hDEADBEEF);
    run_op(1'b1, F3_B, 32'h13, 32'h00000080, rd);
    run_op(1'b0, F3_B, 32'h13, 32'h0, rd);
    check_val("lb_0x13", rd, 32'hFFFFFF80);
    run_op(1'b0, F3_BU, 32'h13, 32'h0, rd);
    check_val("lbu_0x13", rd, 32'h00000080);
    run_op(1'b1, F3_W, 32'h06, 32'h11223344, rd);
    check_val("sw_split_ack", rd, 32'h0);
    run_op(1'b1, F3_B, 32'h7FF, 32'h34, rd);
    run_op(1'b1, F3_B, 32'h000, 32'h92, rd);
    run_op(1'b0, F3_H, 32'h7FF, 32'h0, rd);
    check_val("lh_wrap", rd, 32'hFFFF9234);
    run_op(1'b0, 3'b011, 32'h20, 32'h0, rd);
    run_op(1'b0, F3_W, 32'h800, 32'h0, rd);
    run_op(1'b1, F3_BU, 32'h24, 32'h55, rd);

    // Reset during the second half of a split store.
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h0E; bus.req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_val("rst_test_issue0_we", 32'(bus.mem_we), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_cycle_we", 32'(bus.mem_we), 32'd0);
    check_val("rst_cycle_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("post_rst_ready", 32'(bus.req_ready), 32'd1);
    check_val("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    shadow[14] = 8'hD4;
    shadow[15] = 8'hC3;
    mem_check("partial_write");
    run_op(1'b0, F3_W, 32'h0C, 32'h0, rd);

    for (int it = 0; it < 200; it++) begin
      r_we = 1'($urandom);
      if ($urandom_range(0, 9) == 0) r_f3 = 3'($urandom);
      else case ($urandom_range(0, 4))
        0: r_f3 = F3_B;
        1: r_f3 = F3_H;
        2: r_f3 = F3_W;
        3: r_f3 = F3_BU;
        default: r_f3 = F3_HU;
      endcase
      r_addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES - 1));
      run_op(r_we, r_f3, r_addr, $urandom, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
